countdown_ctrl: RTL
===================

Name: countdown_ctrl

Overview:
- Control stage that sits directly upstream of the 4-bit loadable down-counter.
- Accepts a start request with a load value and drives the counter's IN, latch and dec inputs.
- Paces decrements with a programmable prescaler and watches the counter's zero flag.
- Reports busy/done to the surrounding system, turning the bare counter into a self-running countdown timer.

Parameters:
WIDTH, 4, width of load value and counter data path
PRESCALE, 4, clock cycles per decrement (legal range 1..256)

Ports:
clk       input   1      system clock, all state updates on rising edge
rst       input   1      asynchronous, active-high reset
start     input   1      request to begin a countdown, sampled in IDLE only
stop      input   1      abort current countdown, return to IDLE
load_val  input   WIDTH  countdown start value, captured when start accepted
zero      input   1      counter's zero flag (counter == 0)
cnt_in    output  WIDTH  value driven to counter IN
latch     output  1      counter load strobe
dec       output  1      counter decrement strobe
busy      output  1      high in LOAD and RUN
done      output  1      one-cycle pulse on natural completion

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, load register=0, prescaler=0.
  - cnt_in=0, latch=0, dec=0, busy=0, done=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 and stop=0 at an edge: capture load_val into load register, go LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - latch=1, busy=1.
  - Prescaler cleared to 0; next state RUN.
  - Latency: start sampled at edge N, latch high during cycle N+1, counter holds value after edge N+2.
- RUN:
  - busy=1.
  - Prescaler counts 0..PRESCALE-1, wraps to 0.
  - dec is combinational: dec = (state==RUN) && (prescaler==PRESCALE-1) && !zero. It is a single-cycle strobe, never asserted while zero=1.
  - First dec occurs PRESCALE cycles after entering RUN.
  - zero=1 sampled at an edge while in RUN: go DONE. Prescaler is held.
- DONE (exactly 1 cycle): done=1, busy=0, next state IDLE.
- cnt_in always equals the load register; it is stable from LOAD onward until the next accepted start.
- latch and dec are never high in the same cycle.
- load_val=0: LOAD, then first RUN cycle sees zero=1, then DONE. No dec is issued.
- PRESCALE=1: dec is high every RUN cycle while zero=0.
- stop=1 in LOAD or RUN: next state IDLE. No done pulse; dec/latch drop immediately after the edge. The counter keeps its partial value.
- stop=1 in DONE: done pulse still completes, then IDLE.
- start while busy: ignored, no re-capture.
- start and stop together in IDLE: stop wins, stay IDLE.
- rst mid-countdown: all outputs drop asynchronously to reset values. The counter's contents are not touched by this block.
- Prescaler width is $clog2(PRESCALE) with a minimum of 1 bit. No overflow: it is compared against PRESCALE-1 and reset on wrap.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN
- Defined:
  - On zero=1 in RUN, go DONE (done pulse) and then LOAD instead of IDLE.
  - The counter is reloaded from the held load register, and periodic countdown repeats until stop=1.
  - busy stays 1 throughout, including in DONE.
  - load_val=0 with reload gives a done pulse every 3 cycles (DONE, LOAD, RUN).
- Not defined: single-shot behaviour as above; DONE always returns to IDLE.

Test Plan:
- PRESCALE=4, load_val=3, start pulse, counter attached -> latch 1 cycle after start; dec pulses at 4, 8, 12 cycles into RUN; counter 3→2→1→0; done one cycle after zero seen; exactly 3 dec pulses total.
- load_val=0, start -> latch once, zero dec pulses, done pulse 3 cycles after start edge, busy high for 2 cycles.
- PRESCALE=1, load_val=15 -> 15 consecutive dec cycles, no dec while zero=1, done follows.
- load_val=9, stop asserted after 2nd dec -> IDLE next cycle, no done, counter holds 7; a new start with load_val=5 then completes normally with 5 decs.
- rst asserted mid-RUN between clock edges -> latch/dec/busy/done low immediately (before next edge); start after rst release accepted normally.
- COUNTDOWN_AUTO_RELOAD_EN defined, PRESCALE=2, load_val=2 -> done pulses repeat with period 2*2+3 = 7 cycles, latch each period; stop ends the sequence with busy low next cycle.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Countdown timer control stage driving a loadable down-counter.
// Optional periodic reload when COUNTDOWN_AUTO_RELOAD_EN is defined.
module countdown_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic             zero,
    output logic [WIDTH-1:0] cnt_in,
    output logic             latch,
    output logic             dec,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] load_q;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_nxt;
    logic             pre_wrap;
    logic             accept;

    assign pre_wrap = (pre_q == PMAX);
    assign accept   = (state == IDLE) && start && !stop;
    assign cnt_in   = load_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            load_q <= '0;
            pre_q  <= '0;
        end else begin
            state <= state_nxt;
            pre_q <= pre_nxt;
            if (accept)
                load_q <= load_val;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_q;
        latch     = 1'b0;
        dec       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = LOAD;
            end
            LOAD: begin
                latch     = 1'b1;
                busy      = 1'b1;
                pre_nxt   = '0;
                state_nxt = stop ? IDLE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                dec  = pre_wrap && !zero;
                // prescaler freezes once the counter reaches zero
                if (!zero)
                    pre_nxt = pre_wrap ? '0 : pre_q + PW'(1);
                if (stop)
                    state_nxt = IDLE;
                else if (zero)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                busy      = 1'b1;
                state_nxt = stop ? IDLE : LOAD;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
